// File: rtl/rr_arb8_pkg.sv
// Shared types and sizing constants for the eight-way round-robin arbiter.
package rr_arb8_pkg;
  localparam int unsigned NREQ = 8;
  localparam int unsigned AW   = 3;
  localparam int unsigned HW   = 8;

  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_arb8_dec3to8_n.sv
// Active-low 3-to-8 decoder with active-high enable; drives the one-hot select bus.
module dec3to8_n
  import rr_arb8_pkg::*;
(
  input  logic            GNT_V,
  input  logic [AW-1:0]   GNT_A,
  output logic [NREQ-1:0] GNT_N
);
  always_comb begin
    GNT_N = '1;
    if (GNT_V) GNT_N[GNT_A] = 1'b0;
  end
endmodule

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with bounded hold time and registered grant.
// Optional owner lock is enabled by defining RR_ARB8_LOCK_EN.
module rr_arb8
  import rr_arb8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic [NREQ-1:0] REQ,
`ifdef RR_ARB8_LOCK_EN
  input  logic            LOCK,
`endif
  output logic            GNT_V,
  output logic [AW-1:0]   GNT_A,
  output logic [NREQ-1:0] GNT_N
);
  state_t        state;
  logic [AW-1:0] ptr;
  logic [HW-1:0] hcnt;

  logic            lock;
  logic [NREQ-1:0] others;
  logic [AW:0]     pick_new;
  logic [AW:0]     pick_oth;

  // Rotate so that ptr+1 lands at bit 0, take the lowest set bit, then map back.
  // Result is {found, index}.
  function automatic logic [AW:0] rr_pick(input logic [NREQ-1:0] req,
                                          input logic [AW-1:0]   p);
    logic [AW-1:0]   start;
    logic [NREQ-1:0] rot;
    logic [AW:0]     res;
    start = p + 1'b1;
    for (int unsigned i = 0; i < NREQ; i++) rot[i] = req[AW'(i) + start];
    res = '0;
    for (int unsigned i = NREQ; i > 0; i--)
      if (rot[i-1]) res = {1'b1, AW'(i - 1) + start};
    return res;
  endfunction

`ifdef RR_ARB8_LOCK_EN
  assign lock = LOCK;
`else
  assign lock = 1'b0;
`endif

  // In GRANT ptr always equals the owner, so searching from ptr starts just after it.
  assign others   = REQ & ~(NREQ'(1) << GNT_A);
  assign pick_new = rr_pick(REQ, ptr);
  assign pick_oth = rr_pick(others, ptr);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      GNT_V <= 1'b0;
      GNT_A <= '0;
      ptr   <= '1;
      hcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (EN && pick_new[AW]) begin
            state <= GRANT;
            GNT_V <= 1'b1;
            GNT_A <= pick_new[AW-1:0];
            ptr   <= pick_new[AW-1:0];
            hcnt  <= HW'(1);
          end
        end
        GRANT: begin
          if (!EN) begin
            state <= IDLE;
            GNT_V <= 1'b0;
          end else if (!REQ[GNT_A]) begin
            if (pick_oth[AW]) begin
              GNT_A <= pick_oth[AW-1:0];
              ptr   <= pick_oth[AW-1:0];
              hcnt  <= HW'(1);
            end else begin
              state <= IDLE;
              GNT_V <= 1'b0;
            end
          end else if (hcnt >= HW'(MAX_HOLD)) begin
            if (!lock) begin
              if (pick_oth[AW]) begin
                GNT_A <= pick_oth[AW-1:0];
                ptr   <= pick_oth[AW-1:0];
              end
              hcnt <= HW'(1);
            end
          end else if (hcnt != '1) begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          GNT_V <= 1'b0;
        end
      endcase
    end
  end

  dec3to8_n u_dec (
    .GNT_V (GNT_V),
    .GNT_A (GNT_A),
    .GNT_N (GNT_N)
  );
endmodule

// File: tb/tb_rr_arb8.sv
// Self-checking bench for rr_arb8: per-cycle reference model plus directed literal checks.
module tb_rr_arb8;
  localparam int unsigned MH = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       en   = 1'b0;
  logic       lock = 1'b0;
  logic [7:0] req  = 8'h00;
  logic       gnt_v;
  logic [2:0] gnt_a;
  logic [7:0] gnt_n;

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  rr_arb8 #(.MAX_HOLD(MH)) dut (
    .CLK   (clk),
    .RST   (rst),
    .EN    (en),
    .REQ   (req),
`ifdef RR_ARB8_LOCK_EN
    .LOCK  (lock),
`endif
    .GNT_V (gnt_v),
    .GNT_A (gnt_a),
    .GNT_N (gnt_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester found walking forward from the one after p (wrapping), -1 if none.
  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (p + k) % 8;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Reference model: owner index, last-owner pointer, cycles held.
  bit         m_v   = 1'b0;
  int         m_a   = 0;
  int         m_ptr = 7;
  int         m_h   = 0;
  int         w;
  logic [7:0] oth;
  logic [7:0] expn;

  always @(posedge clk) begin
    if (rst) begin
      m_v = 1'b0; m_a = 0; m_ptr = 7; m_h = 0;
    end else if (!m_v) begin
      if (en && req != 8'h00) begin
        w = pick(req, m_ptr);
        m_v = 1'b1; m_a = w; m_ptr = w; m_h = 1;
      end
    end else begin
      oth = req;
      oth[m_a] = 1'b0;
      if (!en) begin
        m_v = 1'b0;
      end else if (!req[m_a]) begin
        if (oth != 8'h00) begin
          w = pick(oth, m_a);
          m_a = w; m_ptr = w; m_h = 1;
        end else begin
          m_v = 1'b0;
        end
      end else if (m_h >= int'(MH)) begin
        if (!lock) begin
          if (oth != 8'h00) begin
            w = pick(oth, m_a);
            m_a = w; m_ptr = w;
          end
          m_h = 1;
        end
      end else begin
        m_h = (m_h < 255) ? m_h + 1 : 255;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      expn = 8'hFF;
      if (m_v) expn[m_a] = 1'b0;
      check("model_gnt_v", {31'd0, gnt_v}, {31'd0, m_v});
      if (m_v) check("model_gnt_a", {29'd0, gnt_a}, m_a);
      check("model_gnt_n", {24'd0, gnt_n}, {24'd0, expn});
    end
  end

  task automatic cyc(input logic [7:0] r, input logic e, input logic rs);
    req = r; en = e; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(8'h00, 1'b1, 1'b1);
  endtask

  logic [7:0] rr_req [8] = '{8'h85, 8'h85, 8'h84, 8'h84, 8'h80, 8'h80, 8'h01, 8'h01};
  int         rr_exp [8] = '{0, 0, 2, 2, 7, 7, 0, 0};

  initial begin
    // Reset with all requests asserted
    rst = 1'b1; req = 8'hFF; en = 1'b1;
    @(posedge clk); #1;
    armed = 1'b1;
    check("reset_v", {31'd0, gnt_v}, 0);
    check("reset_n", {24'd0, gnt_n}, 32'hFF);
    cyc(8'hFF, 1'b1, 1'b1);
    check("reset_hold_n", {24'd0, gnt_n}, 32'hFF);
    cyc(8'hFF, 1'b1, 1'b0);
    check("first_v", {31'd0, gnt_v}, 1);
    check("first_a", {29'd0, gnt_a}, 0);
    check("first_n", {24'd0, gnt_n}, 32'hFE);

    // Round-robin with owners releasing two cycles after grant
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(rr_req[i], 1'b1, 1'b0);
      check("rr_v", {31'd0, gnt_v}, 1);
      check("rr_owner", {29'd0, gnt_a}, rr_exp[i]);
    end

    // Timeout alternation between two steady requesters
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(8'h03, 1'b1, 1'b0);
      check("timeout_owner", {29'd0, gnt_a}, (i < 4 || i >= 8) ? 0 : 1);
    end

    // Lone owner survives its own timeouts
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(8'h10, 1'b1, 1'b0);
      check("lone_a", {29'd0, gnt_a}, 4);
      check("lone_n", {24'd0, gnt_n}, 32'hEF);
    end

    // EN drop mid-grant
    do_reset();
    cyc(8'h08, 1'b1, 1'b0);
    check("en_owner", {29'd0, gnt_a}, 3);
    cyc(8'h08, 1'b1, 1'b0);
    cyc(8'h08, 1'b0, 1'b0);
    check("en_off_v", {31'd0, gnt_v}, 0);
    check("en_off_n", {24'd0, gnt_n}, 32'hFF);
    cyc(8'h08, 1'b1, 1'b0);
    check("en_regrant_v", {31'd0, gnt_v}, 1);
    check("en_regrant_a", {29'd0, gnt_a}, 3);

    // RST mid-grant restores pointer: 0 must beat 5 afterwards
    do_reset();
    cyc(8'h08, 1'b1, 1'b0);
    check("rst_owner", {29'd0, gnt_a}, 3);
    cyc(8'h29, 1'b1, 1'b0);
    check("rst_hold", {29'd0, gnt_a}, 3);
    cyc(8'h29, 1'b1, 1'b1);
    check("rst_mid_v", {31'd0, gnt_v}, 0);
    cyc(8'h29, 1'b1, 1'b0);
    check("rst_regrant_a", {29'd0, gnt_a}, 0);

`ifdef RR_ARB8_LOCK_EN
    // Lock suppresses timeout; release hands over at once
    do_reset();
    lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(8'h03, 1'b1, 1'b0);
      check("lock_owner", {29'd0, gnt_a}, 0);
    end
    lock = 1'b0;
    cyc(8'h03, 1'b1, 1'b0);
    check("unlock_handover", {29'd0, gnt_a}, 1);
`endif

    // Mixed traffic, EN/RST toggles; checked by the model each cycle
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(8'($urandom), ($urandom_range(0, 15) != 0), ($urandom_range(0, 63) == 0));
    end

    @(negedge clk);
    armed = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
